control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: none; all encodings below are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 CU_instr  input  8  IR contents: [7:4] opcode, [3:2] src reg, [1:0] dest reg.
REQ-005 CU_zero  input  1  registered ALU zero flag (Reg_Z output).
REQ-006 CU_load_reg  output  4  one-hot load enable for R0..R3.
REQ-007 CU_load_PC, CU_inc_PC, CU_load_IR, CU_load_Add_R, CU_load_Reg_Y, CU_load_Reg_Z, CU_write  output  1 each  datapath strobes.
REQ-008 CU_sel_bus1  output  3  bus-1 source: 0-3 = R0-R3, 4 = PC.
REQ-009 CU_sel_bus2  output  2  bus-2 source: 0 = ALU, 1 = bus-1, 2 = memory.
REQ-010 CU_ALU_opcode  output  3  ALU op: 001 add, 010 sub, 011 and, 100 not, 101 nop.
REQ-011 CU_state  output  4  current state code; CU_halted  output  1  high in S_HALT.

Function
REQ-012 Instruction opcodes: 0000 NOP, 0001 ADD, 0010 SUB, 0011 AND, 0100 NOT, 0101 RD, 0110 WR, 0111 BR, 1000 BRZ; 1001-1111 illegal.
REQ-013 RD/WR/BR/BRZ are two-byte; second byte (memory at PC) is the address.
REQ-014 State codes: IDLE 0, FET1 1, FET2 2, DEC 3, EX1 4, RD1 5, RD2 6, WR1 7, WR2 8, BR1 9, BR2 10, HALT 11.
REQ-015 Outputs are combinational from state register and CU_instr/CU_zero; unlisted outputs are 0 and CU_ALU_opcode is 101.
REQ-016 IDLE: no strobes; next FET1.
REQ-017 FET1: sel_bus1=4, sel_bus2=1, load_Add_R, inc_PC; next FET2.
REQ-018 FET2: sel_bus2=2, load_IR; next DEC.
REQ-019 DEC NOP: no strobes; next FET1.
REQ-020 DEC ADD/SUB/AND: sel_bus1=src, sel_bus2=1, load_Reg_Y; next EX1.
REQ-021 DEC NOT: sel_bus1=src, ALU_opcode=100, load_Reg_Z, sel_bus2=0, load_reg[dest]; next FET1.
REQ-022 DEC RD/WR/BR: sel_bus1=4, sel_bus2=1, load_Add_R; next RD1/WR1/BR1 respectively.
REQ-023 DEC BRZ, CU_zero=1: as BR, next BR1; CU_zero=0: inc_PC only (skip address byte), next FET1.
REQ-024 DEC illegal opcode: no strobes; next HALT.
REQ-025 EX1: sel_bus1=dest, ALU_opcode per instr (001/010/011), load_Reg_Z, sel_bus2=0, load_reg[dest]; next FET1.
REQ-026 RD1: sel_bus2=2, load_Add_R, inc_PC; next RD2. RD2: sel_bus2=2, load_reg[dest]; next FET1.
REQ-027 WR1: sel_bus2=2, load_Add_R, inc_PC; next WR2. WR2: sel_bus1=src, write; next FET1.
REQ-028 BR1: sel_bus2=2, load_Add_R; next BR2. BR2: sel_bus2=2, load_PC; next FET1.
REQ-029 HALT: no strobes, CU_halted=1; remains until rst_n asserted.
REQ-030 At most one bit of CU_load_reg high in any cycle; CU_write never high outside WR2.
REQ-031 CU_zero sampled only in DEC; changes elsewhere have no effect.
REQ-032 Latency (cycles, FET1 to next FET1): NOP 3, NOT 3, ADD/SUB/AND 4, RD/WR/BR/BRZ-taken 5, BRZ-not-taken 3.

Reset
REQ-033 rst_n low forces state to IDLE immediately, independent of clk; all strobes 0, CU_ALU_opcode 101, CU_halted 0.
REQ-034 Reset mid-instruction abandons it without completing any pending strobe; execution restarts at FET1 one cycle after rst_n release.
REQ-035 Reset is the only exit from HALT.

Verification
REQ-036 Reset release -> CU_state sequence 0,1,2,3; FET1 shows sel_bus1=4, load_Add_R=1, inc_PC=1.
REQ-037 CU_instr=8'h16 (ADD R1,R2) -> DEC: sel_bus1=1, load_Reg_Y; EX1: sel_bus1=2, ALU_opcode=001, load_reg=4'b0100, load_Reg_Z; then FET1.
REQ-038 CU_instr=8'h53 (RD R3) -> states 3,5,6,1; RD2 load_reg=4'b1000, sel_bus2=2.
REQ-039 CU_instr=8'h80 with CU_zero=0 -> DEC inc_PC=1, next FET1; with CU_zero=1 -> 3,9,10,1 with load_PC in BR2.
REQ-040 CU_instr=8'hF0 -> HALT (11), CU_halted=1, no strobes for 20 cycles; rst_n pulse -> IDLE.
REQ-041 rst_n asserted mid-clock during WR2 -> CU_write drops immediately, CU_state=0 before next edge.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle control unit for a small 8-bit accumulator-less CPU.
// Decodes the IR and sequences datapath strobes through fetch/decode/execute states.
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] CU_instr,
    input  logic       CU_zero,
    output logic [3:0] CU_load_reg,
    output logic       CU_load_PC,
    output logic       CU_inc_PC,
    output logic       CU_load_IR,
    output logic       CU_load_Add_R,
    output logic       CU_load_Reg_Y,
    output logic       CU_load_Reg_Z,
    output logic       CU_write,
    output logic [2:0] CU_sel_bus1,
    output logic [1:0] CU_sel_bus2,
    output logic [2:0] CU_ALU_opcode,
    output logic [3:0] CU_state,
    output logic       CU_halted
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,  S_FET1 = 4'd1, S_FET2 = 4'd2, S_DEC  = 4'd3,
        S_EX1  = 4'd4,  S_RD1  = 4'd5, S_RD2  = 4'd6, S_WR1  = 4'd7,
        S_WR2  = 4'd8,  S_BR1  = 4'd9, S_BR2  = 4'd10, S_HALT = 4'd11
    } state_t;

    localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                           OP_NOT = 4'd4, OP_RD  = 4'd5, OP_WR  = 4'd6, OP_BR  = 4'd7,
                           OP_BRZ = 4'd8;
    localparam logic [2:0] ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011,
                           ALU_NOT = 3'b100, ALU_NOP = 3'b101;
    localparam logic [2:0] BUS1_PC = 3'd4;
    localparam logic [1:0] BUS2_ALU = 2'd0, BUS2_BUS1 = 2'd1, BUS2_MEM = 2'd2;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_opcode;
    logic [1:0] w_src;
    logic [1:0] w_dest;
    logic [3:0] w_dest_1h;

    assign w_opcode  = CU_instr[7:4];
    assign w_src     = CU_instr[3:2];
    assign w_dest    = CU_instr[1:0];
    assign w_dest_1h = 4'b0001 << w_dest;
    assign CU_state  = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        CU_load_reg   = 4'b0000;
        CU_load_PC    = 1'b0;
        CU_inc_PC     = 1'b0;
        CU_load_IR    = 1'b0;
        CU_load_Add_R = 1'b0;
        CU_load_Reg_Y = 1'b0;
        CU_load_Reg_Z = 1'b0;
        CU_write      = 1'b0;
        CU_sel_bus1   = 3'd0;
        CU_sel_bus2   = BUS2_ALU;
        CU_ALU_opcode = ALU_NOP;
        CU_halted     = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FET1;
            S_FET1: begin
                CU_sel_bus1   = BUS1_PC;
                CU_sel_bus2   = BUS2_BUS1;
                CU_load_Add_R = 1'b1;
                CU_inc_PC     = 1'b1;
                w_next        = S_FET2;
            end
            S_FET2: begin
                CU_sel_bus2 = BUS2_MEM;
                CU_load_IR  = 1'b1;
                w_next      = S_DEC;
            end
            S_DEC: begin
                case (w_opcode)
                    OP_NOP: w_next = S_FET1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        CU_sel_bus1   = {1'b0, w_src};
                        CU_sel_bus2   = BUS2_BUS1;
                        CU_load_Reg_Y = 1'b1;
                        w_next        = S_EX1;
                    end
                    OP_NOT: begin
                        CU_sel_bus1   = {1'b0, w_src};
                        CU_ALU_opcode = ALU_NOT;
                        CU_load_Reg_Z = 1'b1;
                        CU_sel_bus2   = BUS2_ALU;
                        CU_load_reg   = w_dest_1h;
                        w_next        = S_FET1;
                    end
                    OP_RD, OP_WR, OP_BR, OP_BRZ: begin
                        // Untaken BRZ only steps PC past its address byte.
                        if (w_opcode == OP_BRZ && !CU_zero) begin
                            CU_inc_PC = 1'b1;
                            w_next    = S_FET1;
                        end else begin
                            CU_sel_bus1   = BUS1_PC;
                            CU_sel_bus2   = BUS2_BUS1;
                            CU_load_Add_R = 1'b1;
                            if (w_opcode == OP_RD)      w_next = S_RD1;
                            else if (w_opcode == OP_WR) w_next = S_WR1;
                            else                        w_next = S_BR1;
                        end
                    end
                    default: w_next = S_HALT;
                endcase
            end
            S_EX1: begin
                CU_sel_bus1 = {1'b0, w_dest};
                case (w_opcode)
                    OP_ADD:  CU_ALU_opcode = ALU_ADD;
                    OP_SUB:  CU_ALU_opcode = ALU_SUB;
                    OP_AND:  CU_ALU_opcode = ALU_AND;
                    default: CU_ALU_opcode = ALU_NOP;
                endcase
                CU_load_Reg_Z = 1'b1;
                CU_sel_bus2   = BUS2_ALU;
                CU_load_reg   = w_dest_1h;
                w_next        = S_FET1;
            end
            S_RD1, S_WR1: begin
                CU_sel_bus2   = BUS2_MEM;
                CU_load_Add_R = 1'b1;
                CU_inc_PC     = 1'b1;
                w_next        = (r_state == S_RD1) ? S_RD2 : S_WR2;
            end
            S_RD2: begin
                CU_sel_bus2 = BUS2_MEM;
                CU_load_reg = w_dest_1h;
                w_next      = S_FET1;
            end
            S_WR2: begin
                CU_sel_bus1 = {1'b0, w_src};
                CU_write    = 1'b1;
                w_next      = S_FET1;
            end
            S_BR1: begin
                CU_sel_bus2   = BUS2_MEM;
                CU_load_Add_R = 1'b1;
                w_next        = S_BR2;
            end
            S_BR2: begin
                CU_sel_bus2 = BUS2_MEM;
                CU_load_PC  = 1'b1;
                w_next      = S_FET1;
            end
            S_HALT: begin
                CU_halted = 1'b1;
                w_next    = S_HALT;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed instruction stream with hand-computed
// per-cycle expectations queued by the stimulus and checked by an independent monitor.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] CU_instr = 8'h00;
    logic       CU_zero = 1'b0;
    logic [3:0] CU_load_reg;
    logic       CU_load_PC, CU_inc_PC, CU_load_IR, CU_load_Add_R;
    logic       CU_load_Reg_Y, CU_load_Reg_Z, CU_write;
    logic [2:0] CU_sel_bus1;
    logic [1:0] CU_sel_bus2;
    logic [2:0] CU_ALU_opcode;
    logic [3:0] CU_state;
    logic       CU_halted;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .CU_instr(CU_instr), .CU_zero(CU_zero),
        .CU_load_reg(CU_load_reg), .CU_load_PC(CU_load_PC), .CU_inc_PC(CU_inc_PC),
        .CU_load_IR(CU_load_IR), .CU_load_Add_R(CU_load_Add_R),
        .CU_load_Reg_Y(CU_load_Reg_Y), .CU_load_Reg_Z(CU_load_Reg_Z),
        .CU_write(CU_write), .CU_sel_bus1(CU_sel_bus1), .CU_sel_bus2(CU_sel_bus2),
        .CU_ALU_opcode(CU_ALU_opcode), .CU_state(CU_state), .CU_halted(CU_halted)
    );

    always #5 clk = ~clk;

    // Strobe vector order: {load_PC, inc_PC, load_IR, load_Add_R, load_Reg_Y, load_Reg_Z, write}
    localparam logic [6:0] NONE = 7'b0000000, LPC = 7'b1000000, IPC = 7'b0100000,
                           LIR  = 7'b0010000, LAR = 7'b0001000, LY  = 7'b0000100,
                           LZ   = 7'b0000010, WRT = 7'b0000001;

    typedef struct {
        string       nm;
        logic [23:0] v;
    } exp_t;

    exp_t queue_e[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic push(input string nm, input logic [3:0] st, input logic [3:0] lr,
                        input logic [6:0] stb, input logic [2:0] s1, input logic [1:0] s2,
                        input logic [2:0] alu, input logic h);
        exp_t e;
        e.nm = nm;
        e.v  = {st, lr, stb, s1, s2, alu, h};
        queue_e.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FET1 and FET2 for the next instruction; caller then ticks into DEC.
    task automatic fetch(input logic [7:0] instr);
        tick();
        CU_instr = instr;
        push("fet1", 4'd1, 4'b0000, IPC | LAR, 3'd4, 2'd1, 3'b101, 1'b0);
        tick();
        push("fet2", 4'd2, 4'b0000, LIR, 3'd0, 2'd2, 3'b101, 1'b0);
        tick();
    endtask

    // Monitor: compares whenever an expectation is pending, on falling clock or reset assertion.
    initial begin
        logic [23:0] act;
        exp_t        e;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (queue_e.size() > 0) begin
                e   = queue_e.pop_front();
                act = {CU_state, CU_load_reg, CU_load_PC, CU_inc_PC, CU_load_IR,
                       CU_load_Add_R, CU_load_Reg_Y, CU_load_Reg_Z, CU_write,
                       CU_sel_bus1, CU_sel_bus2, CU_ALU_opcode, CU_halted};
                n_checks++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h (state %0d vs %0d)",
                             e.nm, act, e.v, act[23:20], e.v[23:20]);
                end
                n_checks++;
                if ($countones(CU_load_reg) > 1 || (CU_write && CU_state != 4'd8)) begin
                    n_fail++;
                    $display("FAIL %s_invariant: load_reg=%b write=%b state=%0d, required onehot0 and write only in state 8",
                             e.nm, CU_load_reg, CU_write, CU_state);
                end
            end
        end
    end

    initial begin
        // Reset held, then released
        tick(); push("rst_idle0", 4'd0, 4'b0000, NONE, 3'd0, 2'd0, 3'b101, 1'b0);
        tick(); push("rst_idle1", 4'd0, 4'b0000, NONE, 3'd0, 2'd0, 3'b101, 1'b0);
        rst_n = 1'b1;
        // NOP
        fetch(8'h00);
        push("nop_dec", 4'd3, 4'b0000, NONE, 3'd0, 2'd0, 3'b101, 1'b0);
        // ADD R1,R2: src 1, dest 2
        fetch(8'h16);
        push("add_dec", 4'd3, 4'b0000, LY, 3'd1, 2'd1, 3'b101, 1'b0);
        tick(); push("add_ex1", 4'd4, 4'b0100, LZ, 3'd2, 2'd0, 3'b001, 1'b0);
        // SUB src 2, dest 3
        fetch(8'h2B);
        push("sub_dec", 4'd3, 4'b0000, LY, 3'd2, 2'd1, 3'b101, 1'b0);
        tick(); push("sub_ex1", 4'd4, 4'b1000, LZ, 3'd3, 2'd0, 3'b010, 1'b0);
        // AND src 0, dest 1
        fetch(8'h31);
        push("and_dec", 4'd3, 4'b0000, LY, 3'd0, 2'd1, 3'b101, 1'b0);
        tick(); push("and_ex1", 4'd4, 4'b0010, LZ, 3'd1, 2'd0, 3'b011, 1'b0);
        // NOT src 3, dest 2
        fetch(8'h4E);
        push("not_dec", 4'd3, 4'b0100, LZ, 3'd3, 2'd0, 3'b100, 1'b0);
        // RD R3
        fetch(8'h53);
        push("rd_dec", 4'd3, 4'b0000, LAR, 3'd4, 2'd1, 3'b101, 1'b0);
        tick(); push("rd1", 4'd5, 4'b0000, LAR | IPC, 3'd0, 2'd2, 3'b101, 1'b0);
        tick(); push("rd2", 4'd6, 4'b1000, NONE, 3'd0, 2'd2, 3'b101, 1'b0);
        // WR src 2
        fetch(8'h69);
        push("wr_dec", 4'd3, 4'b0000, LAR, 3'd4, 2'd1, 3'b101, 1'b0);
        tick(); push("wr1", 4'd7, 4'b0000, LAR | IPC, 3'd0, 2'd2, 3'b101, 1'b0);
        tick(); push("wr2", 4'd8, 4'b0000, WRT, 3'd2, 2'd0, 3'b101, 1'b0);
        // BRZ not taken; zero high during fetch must not matter
        CU_zero = 1'b1;
        fetch(8'h80);
        CU_zero = 1'b0;
        push("brz_nt_dec", 4'd3, 4'b0000, IPC, 3'd0, 2'd0, 3'b101, 1'b0);
        // BRZ taken; zero dropping after DEC must not matter
        fetch(8'h80);
        CU_zero = 1'b1;
        push("brz_t_dec", 4'd3, 4'b0000, LAR, 3'd4, 2'd1, 3'b101, 1'b0);
        tick(); CU_zero = 1'b0;
        push("brz_br1", 4'd9, 4'b0000, LAR, 3'd0, 2'd2, 3'b101, 1'b0);
        tick(); push("brz_br2", 4'd10, 4'b0000, LPC, 3'd0, 2'd2, 3'b101, 1'b0);
        // BR
        fetch(8'h70);
        push("br_dec", 4'd3, 4'b0000, LAR, 3'd4, 2'd1, 3'b101, 1'b0);
        tick(); push("br_br1", 4'd9, 4'b0000, LAR, 3'd0, 2'd2, 3'b101, 1'b0);
        tick(); push("br_br2", 4'd10, 4'b0000, LPC, 3'd0, 2'd2, 3'b101, 1'b0);
        // WR interrupted by reset mid-WR2
        fetch(8'h6C);
        push("wr_dec_b", 4'd3, 4'b0000, LAR, 3'd4, 2'd1, 3'b101, 1'b0);
        tick(); push("wr1_b", 4'd7, 4'b0000, LAR | IPC, 3'd0, 2'd2, 3'b101, 1'b0);
        tick(); push("wr2_b", 4'd8, 4'b0000, WRT, 3'd3, 2'd0, 3'b101, 1'b0);
        #6;
        push("wr2_async_rst", 4'd0, 4'b0000, NONE, 3'd0, 2'd0, 3'b101, 1'b0);
        rst_n = 1'b0;
        tick(); push("rst_hold", 4'd0, 4'b0000, NONE, 3'd0, 2'd0, 3'b101, 1'b0);
        rst_n = 1'b1;
        // Illegal opcode halts
        fetch(8'hF0);
        push("ill_dec", 4'd3, 4'b0000, NONE, 3'd0, 2'd0, 3'b101, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            CU_zero  = i[0];
            CU_instr = (i[1]) ? 8'h16 : 8'h00;
            push("halt", 4'd11, 4'b0000, NONE, 3'd0, 2'd0, 3'b101, 1'b1);
        end
        #6;
        push("halt_rst", 4'd0, 4'b0000, NONE, 3'd0, 2'd0, 3'b101, 1'b0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        fetch(8'h00);
        push("post_halt_dec", 4'd3, 4'b0000, NONE, 3'd0, 2'd0, 3'b101, 1'b0);
        // Bounded drain of outstanding expectations
        for (int i = 0; i < 5 && queue_e.size() > 0; i++) tick();
        n_checks++;
        if (queue_e.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", queue_e.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
